// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/shift coprocessor.
//   ALU control words ordered {zx,nx,zy,ny,f,no}, sequencer states,
//   op encodings, and the state-selection rule used after every mr update.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000010;
  localparam logic [5:0] ALU_ZERO  = 6'b101010;
  localparam logic [5:0] ALU_PASSX = 6'b001100;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_SHL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Where to go once mr holds its new value: finished when nothing is left,
  // an accumulate step when the current multiplier bit is set, else a doubling.
  function automatic state_t next_step(input logic [15:0] mr_new, input logic op_is_shl);
    if (mr_new == 16'd0)
      return DONE;
    else if (!op_is_shl && mr_new[0])
      return ADD;
    else
      return DBL;
  endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake bundle for alu_mul_seq.
//   in_valid/in_ready/op/a/b : request side
//   out_valid/out_ready/result/zr/ng : result side
// The sequencer uses the slave modport, the requester/consumer the master.
interface alu_mul_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zr, ng
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zr, ng
  );
endinterface

// File: rtl/alu.sv
// Hack ALU, purely combinational.
//   x, y     : operands
//   zx..no   : control bits (zero/negate x, zero/negate y, add-vs-and, negate out)
//   out      : result; zr = (out == 0); ng = out[MSB]
module alu #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x1, x2, y1, y2, fo;

  always_comb begin
    x1  = zx ? '0 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? '0 : y;
    y2  = ny ? ~y1 : y1;
    fo  = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~fo : fo;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end
endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle MUL / SHL coprocessor that time-shares one Hack ALU.
//   clk   : rising-edge clock
//   reset : synchronous, active high
//   bus   : alu_mul_seq_if.slave (request in, result out, zr/ng flags)
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request; ALU idles on ZERO
// ADD   | MUL only: acc <= acc + mc
// DBL   | mc <= mc + mc; mr shifts right (MUL) or counts down (SHL)
// DONE  | out_valid=1, result held until out_ready
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_mul_seq_if.slave   bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mc, mc_nxt;
  logic [WIDTH-1:0] mr, mr_nxt;
  logic             opr, opr_nxt;

  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctl;
  logic [WIDTH-1:0] mr_load, mr_step;
  logic             alu_zr_unused, alu_ng_unused;

  alu #(.WIDTH(WIDTH)) u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (alu_ctl[5]),
    .nx  (alu_ctl[4]),
    .zy  (alu_ctl[3]),
    .ny  (alu_ctl[2]),
    .f   (alu_ctl[1]),
    .no  (alu_ctl[0]),
    .out (alu_out),
    .zr  (alu_zr_unused),
    .ng  (alu_ng_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mc    <= '0;
      mr    <= '0;
      opr   <= OP_MUL;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      mc    <= mc_nxt;
      mr    <= mr_nxt;
      opr   <= opr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mc_nxt    = mc;
    mr_nxt    = mr;
    opr_nxt   = opr;
    alu_ctl   = ALU_ZERO;
    alu_x     = acc;
    alu_y     = mc;
    // SHL only ever counts down a 4-bit shift amount.
    mr_load   = (bus.op == OP_SHL) ? {{(WIDTH-4){1'b0}}, bus.b[3:0]} : bus.b;
    mr_step   = (opr == OP_SHL) ? (mr - 1'b1) : (mr >> 1);

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          acc_nxt   = '0;
          mc_nxt    = bus.a;
          opr_nxt   = bus.op;
          mr_nxt    = mr_load;
          state_nxt = next_step(mr_load, bus.op);
        end
      end
      ADD: begin
        alu_ctl   = ALU_ADD;
        alu_x     = acc;
        alu_y     = mc;
        acc_nxt   = alu_out;
        state_nxt = DBL;
      end
      DBL: begin
        alu_ctl   = ALU_ADD;
        alu_x     = mc;
        alu_y     = mc;
        mc_nxt    = alu_out;
        mr_nxt    = mr_step;
        state_nxt = next_step(mr_step, opr);
      end
      DONE: begin
        if (bus.out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = (opr == OP_SHL) ? mc : acc;
    bus.zr        = (bus.result == '0);
    bus.ng        = bus.result[WIDTH-1];
  end

endmodule
